// File: rtl/dmem_arbiter.sv
// 256-byte little-endian data memory shared by the CPU MEM stage and a debug/loader port.
// One access per cycle; CPU has priority, debug is forced through after STARVE_LIM denials.
module dmem_arbiter #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 32,
  parameter int STARVE_LIM = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_ack,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic [1:0]        owner
);

  localparam int DEPTH  = 1 << ADDR_W;
  localparam int NBYTES = DATA_W / 8;
  localparam logic [3:0] LIM = 4'(STARVE_LIM);

  typedef enum logic [1:0] {S_IDLE, S_ACK, S_WAIT} state_t;

  state_t            r_state, w_state_nxt;
  logic [3:0]        r_starve, w_starve_nxt;
  logic [7:0]        r_mem [DEPTH];
  logic [DATA_W-1:0] r_cpu_rdata, r_dbg_rdata;

  logic              w_dbg_pending, w_force, w_dbg_win, w_cpu_win;
  logic              w_acc_we, w_wr_en;
  logic [ADDR_W-1:0] w_acc_addr;
  logic [DATA_W-1:0] w_acc_wdata, w_rd_word;

  assign w_dbg_pending = dbg_req & (r_state == S_IDLE);
  assign w_force       = (r_starve >= LIM);
  assign w_dbg_win     = w_dbg_pending & (~cpu_req | w_force);
  assign w_cpu_win     = cpu_req & ~w_dbg_win;

  assign cpu_stall = cpu_req & ~w_cpu_win;
  assign owner     = w_dbg_win ? 2'b10 : (w_cpu_win ? 2'b01 : 2'b00);
  assign dbg_ack   = (r_state == S_ACK);
  assign cpu_rdata = r_cpu_rdata;
  assign dbg_rdata = r_dbg_rdata;

  // The single memory port is steered to whichever side won this cycle.
  assign w_acc_addr  = w_dbg_win ? dbg_addr  : cpu_addr;
  assign w_acc_wdata = w_dbg_win ? dbg_wdata : cpu_wdata;
  assign w_acc_we    = w_dbg_win ? dbg_we    : (w_cpu_win & cpu_we);
  assign w_wr_en     = w_acc_we & rst_n;

  always_comb begin
    w_rd_word = '0;
    for (int k = 0; k < NBYTES; k++)
      w_rd_word[8*k +: 8] = r_mem[w_acc_addr + ADDR_W'(k)];
  end

  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      for (int k = 0; k < NBYTES; k++)
        r_mem[w_acc_addr + ADDR_W'(k)] <= w_acc_wdata[8*k +: 8];
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_dbg_win) w_state_nxt = S_ACK;
      S_ACK:   w_state_nxt = S_WAIT;
      S_WAIT:  if (!dbg_req) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_starve_nxt = r_starve;
    if (w_dbg_win || !dbg_req)
      w_starve_nxt = '0;
    else if (w_dbg_pending && r_starve != 4'hF)
      w_starve_nxt = r_starve + 4'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_starve    <= '0;
      r_cpu_rdata <= '0;
      r_dbg_rdata <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_starve <= w_starve_nxt;
      if (w_cpu_win && !cpu_we)
        r_cpu_rdata <= w_rd_word;
      if (w_dbg_win && !dbg_we)
        r_dbg_rdata <= w_rd_word;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: stimulus pushes expected read data, a monitor pops on each response.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_req, cpu_we, cpu_stall;
  logic [7:0]  cpu_addr;
  logic [31:0] cpu_wdata, cpu_rdata;
  logic        dbg_req, dbg_we, dbg_ack;
  logic [7:0]  dbg_addr;
  logic [31:0] dbg_wdata, dbg_rdata;
  logic [1:0]  owner;

  typedef struct {
    logic [31:0] d;
    logic [31:0] m;
  } exp_t;

  exp_t cpu_q[$];
  exp_t dbg_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  logic ld_prev = 1'b0;

  dmem_arbiter #(.ADDR_W(8), .DATA_W(32), .STARVE_LIM(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata), .owner(owner)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: a CPU load accepted in one cycle is checked at the next negedge; every ack pops one dbg entry.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (ld_prev && rst_n) begin
        if (cpu_q.size() == 0) chk("cpu_load_unexpected", 32'd1, 32'd0);
        else begin
          e = cpu_q.pop_front();
          chk("cpu_rdata", cpu_rdata & e.m, e.d & e.m);
        end
      end
      ld_prev = rst_n & cpu_req & ~cpu_we & ~cpu_stall;
      if (dbg_ack) begin
        if (dbg_q.size() == 0) chk("dbg_ack_unexpected", {31'd0, dbg_ack}, 32'd0);
        else begin
          e = dbg_q.pop_front();
          chk("dbg_rdata", dbg_rdata & e.m, e.d & e.m);
        end
      end
    end
  end

  task automatic cpu_acc(input logic we, input logic [7:0] a, input logic [31:0] d,
                         input logic [31:0] exp, input logic [31:0] m);
    exp_t e;
    cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
    if (!we) begin
      e.d = exp; e.m = m;
      cpu_q.push_back(e);
    end
    @(negedge clk);
    chk("cpu_stall_idle", {31'd0, cpu_stall}, 32'd0);
    chk("cpu_owner", {30'd0, owner}, 32'd1);
    tick();
    cpu_req = 1'b0;
  endtask

  task automatic dbg_acc(input logic we, input logic [7:0] a, input logic [31:0] d,
                         input logic [31:0] exp, input logic [31:0] m, input int hold);
    exp_t e;
    logic got;
    dbg_req = 1'b1; dbg_we = we; dbg_addr = a; dbg_wdata = d;
    e.d = exp; e.m = we ? 32'd0 : m;
    dbg_q.push_back(e);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = dbg_ack;
      tick();
    end
    chk("dbg_ack_seen", {31'd0, got}, 32'd1);
    repeat (hold) tick();
    dbg_req = 1'b0;
    tick();
  endtask

  initial begin
    rst_n = 1'b0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
    repeat (3) tick();
    @(negedge clk);
    chk("rst_cpu_rdata", cpu_rdata, 32'd0);
    chk("rst_dbg_rdata", dbg_rdata, 32'd0);
    chk("rst_dbg_ack", {31'd0, dbg_ack}, 32'd0);
    chk("rst_owner", {30'd0, owner}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Store then load, plus misaligned load picking up byte 0x10 as the top byte.
    cpu_acc(1'b1, 8'h10, 32'hDEADBEEF, 32'd0, 32'd0);
    cpu_acc(1'b0, 8'h10, 32'd0, 32'hDEADBEEF, 32'hFFFFFFFF);
    cpu_acc(1'b0, 8'h0D, 32'd0, 32'hEF000000, 32'hFF000000);

    // Wrap-around store at 0xFE; debug read at 0x00 sees the upper half.
    cpu_acc(1'b1, 8'hFE, 32'h11223344, 32'd0, 32'd0);
    dbg_acc(1'b0, 8'h00, 32'd0, 32'h00001122, 32'h0000FFFF, 0);

    // Starvation: four denials, forced win on the fifth cycle, ack on the sixth.
    begin
      exp_t e;
      e.d = 32'hDEADBEEF; e.m = 32'hFFFFFFFF;
      dbg_q.push_back(e);
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h80; cpu_wdata = 32'd0;
      dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 8'h10;
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        chk("starve_owner_cpu", {30'd0, owner}, 32'd1);
        chk("starve_stall_lo", {31'd0, cpu_stall}, 32'd0);
        tick();
      end
      @(negedge clk);
      chk("force_owner_dbg", {30'd0, owner}, 32'd2);
      chk("force_stall_hi", {31'd0, cpu_stall}, 32'd1);
      tick();
      @(negedge clk);
      chk("force_ack", {31'd0, dbg_ack}, 32'd1);
      chk("force_stall_after", {31'd0, cpu_stall}, 32'd0);
      tick();
      cpu_req = 1'b0; dbg_req = 1'b0;
      tick();
    end

    // Debug write with req held six cycles past the ack: one grant only.
    begin
      exp_t e;
      e.d = 32'd0; e.m = 32'd0;
      dbg_q.push_back(e);
      dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 8'h20; dbg_wdata = 32'h000000AA;
      @(negedge clk);
      chk("hold_owner_grant", {30'd0, owner}, 32'd2);
      tick();
      @(negedge clk);
      chk("hold_ack", {31'd0, dbg_ack}, 32'd1);
      tick();
      for (int i = 0; i < 6; i++) begin
        @(negedge clk);
        chk("hold_owner_wait", {30'd0, owner}, 32'd0);
        tick();
      end
      dbg_req = 1'b0;
      tick();
    end
    dbg_acc(1'b0, 8'h20, 32'd0, 32'h000000AA, 32'hFFFFFFFF, 0);

    // Same-address collision: CPU writes first, debug overwrites after.
    begin
      exp_t e;
      e.d = 32'd0; e.m = 32'd0;
      dbg_q.push_back(e);
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h40; cpu_wdata = 32'h5;
      dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 8'h40; dbg_wdata = 32'h7;
      @(negedge clk);
      chk("collide_owner_cpu", {30'd0, owner}, 32'd1);
      tick();
      cpu_req = 1'b0;
      @(negedge clk);
      chk("collide_owner_dbg", {30'd0, owner}, 32'd2);
      tick();
      @(negedge clk);
      chk("collide_ack", {31'd0, dbg_ack}, 32'd1);
      tick();
      dbg_req = 1'b0;
      tick();
    end
    cpu_acc(1'b0, 8'h40, 32'd0, 32'h7, 32'hFFFFFFFF);

    // Reset while in ACK: the ack drops immediately.
    cpu_acc(1'b1, 8'h30, 32'h9, 32'd0, 32'd0);
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 8'h30;
    @(negedge clk);
    chk("rst_ack_grant", {30'd0, owner}, 32'd2);
    tick();
    rst_n = 1'b0;
    #1;
    chk("rst_ack_drop", {31'd0, dbg_ack}, 32'd0);
    chk("rst_cpu_rdata_mid", cpu_rdata, 32'd0);
    dbg_req = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();

    // Reset across the edge of a granted debug write: 0x30 keeps 0x9.
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 8'h30; dbg_wdata = 32'h55;
    @(negedge clk);
    chk("rst_wr_grant", {30'd0, owner}, 32'd2);
    #1;
    rst_n = 1'b0;
    tick();
    dbg_req = 1'b0;
    chk("rst_wr_ack", {31'd0, dbg_ack}, 32'd0);
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_rel_owner", {30'd0, owner}, 32'd0);
    chk("rst_rel_ack", {31'd0, dbg_ack}, 32'd0);
    tick();
    dbg_acc(1'b0, 8'h30, 32'd0, 32'h9, 32'hFFFFFFFF, 1);
    cpu_acc(1'b0, 8'h30, 32'd0, 32'h9, 32'hFFFFFFFF);

    repeat (3) tick();
    chk("cpu_q_drained", cpu_q.size(), 32'd0);
    chk("dbg_q_drained", dbg_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Owns the 256-byte, byte-addressed, little-endian data memory.
- Shares its single access slot per cycle between the pipeline MEM stage (cpu port) and a debug/loader port (dbg port).
- CPU has priority; a starvation limit guarantees debug progress.
- Stalls the pipeline when the CPU loses arbitration and gives debug a req/ack handshake.

Parameters:
- ADDR_W, 8, byte address width; memory depth is 2**ADDR_W bytes.
- DATA_W, 32, word width; fixed at 4 bytes per access.
- STARVE_LIM, 4, consecutive cycles a pending dbg request may be denied before it is forced to win (range 1..15).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- cpu_req  input  1  MEM stage requests an access this cycle.
- cpu_we  input  1  1 = store, 0 = load.
- cpu_addr  input  ADDR_W  byte address of the least-significant byte.
- cpu_wdata  input  DATA_W  store data.
- cpu_rdata  output  DATA_W  load data, registered.
- cpu_stall  output  1  CPU access not taken this cycle; pipeline holds.
- dbg_req  input  1  debug access request, level, held until dbg_ack.
- dbg_we  input  1  1 = write, 0 = read.
- dbg_addr  input  ADDR_W  byte address.
- dbg_wdata  input  DATA_W  write data.
- dbg_ack  output  1  one-cycle pulse: dbg access completed.
- dbg_rdata  output  DATA_W  debug read data; valid while dbg_ack=1 and held afterwards.
- owner  output  2  00 idle, 01 cpu, 10 dbg: winner of the current cycle (combinational).

Behaviour:
- Reset (rst_n=0, asynchronous):
  - cpu_rdata=0, dbg_rdata=0, dbg_ack=0, starve counter=0, FSM=IDLE.
  - Memory contents are not reset.
  - cpu_stall and owner follow the arbitration equations below (owner=00 while dbg is not pending).
- Word access:
  - Bytes at a, a+1, a+2, a+3 map to data[7:0], [15:8], [23:16], [31:24].
  - Address arithmetic is modulo 2**ADDR_W; e.g. a=0xFE touches 0xFE, 0xFF, 0x00, 0x01.
  - Misaligned addresses are legal.
- Arbitration (combinational, evaluated each cycle):
  - dbg_pending = dbg_req & (FSM==IDLE).
  - force = starve counter >= STARVE_LIM.
  - dbg wins if dbg_pending & (~cpu_req | force); otherwise cpu wins if cpu_req.
  - cpu_stall = cpu_req & ~cpu_win.
- Starve counter:
  - Increments (saturating at 15) on each cycle with dbg_pending=1 that dbg loses.
  - Clears on a dbg win or when dbg_req=0.
- CPU access (cpu wins):
  - Store writes 4 bytes at the clock edge.
  - Load: cpu_rdata is updated at that edge, one-cycle latency, and consumed by WB next cycle.
  - cpu_rdata holds its value when there is no CPU load.
- FSM, debug side:
  - IDLE: dbg win performs the access at the edge (read into dbg_rdata), then -> ACK.
  - ACK: dbg_ack=1 for exactly this cycle, -> WAIT.
  - WAIT: stays until dbg_req=0, then -> IDLE.
  - dbg is never granted outside IDLE, so each req level yields exactly one access and one ack. This blocks double access when the requester drops req late.
- Simultaneous events:
  - cpu and dbg to the same address in one cycle: only the winner accesses; the loser repeats later and sees the winner's write.
  - dbg_req dropping in IDLE before a grant abandons the request, with no access and no ack.
  - cpu_req with cpu_win means the access is done; the pipeline advances.
- Reset mid-operation:
  - A grant in progress at reset assertion is cancelled; no write occurs at a clock edge while rst_n=0.
  - FSM returns to IDLE; ack is never emitted for a pre-reset request.
- No X propagation: all outputs are defined whenever rst_n has been asserted once.

Test Plan:
- Reset, then cpu store 0xDEADBEEF at 0x10, then cpu load 0x10 -> cpu_stall=0 both cycles; cpu_rdata=0xDEADBEEF one cycle after the load; byte 0x10=0xEF.
- cpu store 0x11223344 at 0xFE, dbg read 0x00 -> dbg_rdata=0x????1122 with bytes 0x00=0x22, 0x01=0x11 (wrap); single dbg_ack pulse.
- cpu_req=1 continuously with dbg_req=1 and STARVE_LIM=4 -> dbg denied 4 cycles; 5th cycle owner=10 and cpu_stall=1 for that cycle only; dbg_ack next cycle.
- dbg write 0x000000AA to 0x20 with req held 6 cycles after ack -> exactly one write, one ack, no second grant; owner stays 01/00 during WAIT.
- Same cycle: cpu store 0x5 and dbg write 0x7 at 0x40, cpu wins -> then dbg writes; final word at 0x40 = 0x7; cpu load returns 0x7.
- rst_n pulled low while in ACK and while a dbg write is granted -> dbg_ack=0 immediately, no write at 0x30 (prior value 0x9 preserved), FSM=IDLE after release.
